// File: rtl/cfg_cmd_pkg.sv
// Shared opcodes, defaults, FSM encodings and reply helpers for the mode-3
// configuration command engine.
package cfg_cmd_pkg;

  localparam logic [7:0] HEAD_SAVE   = 8'hC0;
  localparam logic [7:0] RET_CONFIG  = 8'hC1;
  localparam logic [7:0] HEAD_TEMP   = 8'hC2;
  localparam logic [7:0] RET_VERSION = 8'hC3;
  localparam logic [7:0] RESET_CMD   = 8'hC4;

  localparam logic [31:0] VERSION_WORD = 32'hC332_2702;
  localparam logic [39:0] DEF_CONFIG   = 40'h00_00_1A_17_44;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RX_PARAM  = 3'd1;
  localparam logic [2:0] ST_RX_REPEAT = 3'd2;
  localparam logic [2:0] ST_COMMIT    = 3'd3;
  localparam logic [2:0] ST_TX_REPLY  = 3'd4;

  localparam logic [2:0] PARAM_BYTES   = 3'd5;
  localparam logic [2:0] REPLY_LEN_CFG = 3'd6;
  localparam logic [2:0] REPLY_LEN_VER = 3'd4;

  typedef struct packed {
    logic [7:0] addh;
    logic [7:0] addl;
    logic [7:0] sped;
    logic [7:0] chan;
    logic [7:0] option;
  } cfg_t;

  // Reply slot [0] goes out first; version bytes leave MSB first.
  localparam logic [5:0][7:0] VERSION_REPLY = {16'h0000, VERSION_WORD[7:0],
    VERSION_WORD[15:8], VERSION_WORD[23:16], VERSION_WORD[31:24]};

  function automatic logic [5:0][7:0] cfg_reply(input logic [7:0] head, input cfg_t c);
    cfg_reply = {c.option, c.chan, c.sped, c.addl, c.addh, head};
  endfunction

endpackage

// File: rtl/cfg_rx_timeout.sv
// Inter-byte idle counter: cleared by every accepted byte, held at zero while
// disabled, saturates at LIMIT and flags expiry.
module cfg_rx_timeout #(
  parameter int LIMIT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (clr_i || !en_i)   cnt_q <= '0;
    else if (cnt_q != MAX)     cnt_q <= cnt_q + 1'b1;
  end

  assign expired_o = (cnt_q == MAX);

endmodule

// File: rtl/config_cmd_sequencer.sv
// Mode-3 command engine: parses framed UART bytes, updates the config
// registers and paces reply bytes out through the MCU UART TX.
module config_cmd_sequencer
  import cfg_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RX_TIMEOUT = 500000
) (
  input  logic                  internal_clk,
  input  logic                  rst_n,
  input  logic                  cfg_mode_en,
  input  logic                  rx_flag_mcu,
  input  logic [DATA_WIDTH-1:0] data_from_uart_mcu,
  input  logic                  tx_busy_mcu,
  output logic                  tx_use_mcu,
  output logic [DATA_WIDTH-1:0] data_to_uart_mcu,
  output logic [7:0]            addh,
  output logic [7:0]            addl,
  output logic [7:0]            sped,
  output logic [7:0]            chan,
  output logic [7:0]            option,
  output logic                  cfg_save,
  output logic                  soft_reset_req,
  output logic                  busy
);

  logic [2:0]      state_q, state_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      rep_q, rep_d;
  logic [4:0][7:0] sh_q, sh_d;
  cfg_t            cfg_q, cfg_d;
  logic [5:0][7:0] rbuf_q, rbuf_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      len_q, len_d;
  logic            use_q, use_d;
  logic            gap_q, gap_d;
  logic [7:0]      dout_q, dout_d;
  logic            save_q, save_d;
  logic            srst_q, srst_d;
  logic            rx_ok, in_rx, expired;
  cfg_t            sh_cfg;

  assign rx_ok  = rx_flag_mcu & cfg_mode_en;
  assign in_rx  = (state_q == ST_RX_PARAM) || (state_q == ST_RX_REPEAT);
  assign sh_cfg = cfg_t'({sh_q[0], sh_q[1], sh_q[2], sh_q[3], sh_q[4]});

  cfg_rx_timeout #(.LIMIT(RX_TIMEOUT)) u_tmo (
    .clk       (internal_clk),
    .rst_n     (rst_n),
    .clr_i     (rx_ok),
    .en_i      (in_rx),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    sh_d    = sh_q;
    cfg_d   = cfg_q;
    rbuf_d  = rbuf_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    gap_d   = gap_q;
    dout_d  = dout_q;
    use_d   = 1'b0;
    save_d  = 1'b0;
    srst_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_ok) begin
          case (data_from_uart_mcu[7:0])
            HEAD_SAVE, HEAD_TEMP: begin
              hdr_d   = data_from_uart_mcu[7:0];
              idx_d   = '0;
              state_d = ST_RX_PARAM;
            end
            RET_CONFIG, RET_VERSION, RESET_CMD: begin
              hdr_d   = data_from_uart_mcu[7:0];
              rep_d   = 2'd1;
              state_d = ST_RX_REPEAT;
            end
            default: ;
          endcase
        end
      end
      ST_RX_PARAM: begin
        if (!cfg_mode_en) state_d = ST_IDLE;
        else if (rx_flag_mcu) begin
          sh_d[idx_q] = data_from_uart_mcu[7:0];
          idx_d       = idx_q + 3'd1;
          if (idx_q == PARAM_BYTES - 3'd1) state_d = ST_COMMIT;
        end else if (expired) state_d = ST_IDLE;
      end
      ST_RX_REPEAT: begin
        // A mismatching byte just ends the frame; it is never re-parsed as a header.
        if (!cfg_mode_en) state_d = ST_IDLE;
        else if (rx_flag_mcu) begin
          if (data_from_uart_mcu[7:0] != hdr_q) state_d = ST_IDLE;
          else if (rep_q == 2'd2)               state_d = ST_COMMIT;
          else                                  rep_d   = rep_q + 2'd1;
        end else if (expired) state_d = ST_IDLE;
      end
      ST_COMMIT: begin
        ptr_d   = '0;
        gap_d   = 1'b0;
        state_d = ST_TX_REPLY;
        case (hdr_q)
          RESET_CMD: begin
            srst_d  = 1'b1;
            state_d = ST_IDLE;
          end
          RET_VERSION: begin
            rbuf_d = VERSION_REPLY;
            len_d  = REPLY_LEN_VER;
          end
          RET_CONFIG: begin
            rbuf_d = cfg_reply(HEAD_SAVE, cfg_q);
            len_d  = REPLY_LEN_CFG;
          end
          default: begin
            cfg_d  = sh_cfg;
            save_d = (hdr_q == HEAD_SAVE);
            rbuf_d = cfg_reply(hdr_q, sh_cfg);
            len_d  = REPLY_LEN_CFG;
          end
        endcase
      end
      ST_TX_REPLY: begin
        // Strobe, then one gap cycle so the UART's busy flag is visible before the next byte.
        if (use_q) begin
          gap_d = 1'b1;
          if (ptr_q == len_q) state_d = ST_IDLE;
        end else if (gap_q) begin
          gap_d = 1'b0;
        end else if (!tx_busy_mcu) begin
          use_d  = 1'b1;
          dout_d = rbuf_q[ptr_q];
          ptr_d  = ptr_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      sh_q    <= '0;
      cfg_q   <= cfg_t'(DEF_CONFIG);
      rbuf_q  <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      use_q   <= 1'b0;
      gap_q   <= 1'b0;
      dout_q  <= '0;
      save_q  <= 1'b0;
      srst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      sh_q    <= sh_d;
      cfg_q   <= cfg_d;
      rbuf_q  <= rbuf_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      use_q   <= use_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      save_q  <= save_d;
      srst_q  <= srst_d;
    end
  end

  assign tx_use_mcu       = use_q;
  assign data_to_uart_mcu = DATA_WIDTH'(dout_q);
  assign addh             = cfg_q.addh;
  assign addl             = cfg_q.addl;
  assign sped             = cfg_q.sped;
  assign chan             = cfg_q.chan;
  assign option           = cfg_q.option;
  assign cfg_save         = save_q;
  assign soft_reset_req   = srst_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_config_cmd_sequencer.sv
// Directed bench for config_cmd_sequencer: table of command frames plus
// hand-written sequences for busy back-pressure, abort, reset and timeout.
module tb_config_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b1;
  logic       rx = 1'b0;
  logic [7:0] din = 8'h00;
  logic       txb = 1'b0;
  logic       tx_use, cfg_save, srst, busy;
  logic [7:0] dout, addh, addl, sped, chan, option;

  config_cmd_sequencer #(.DATA_WIDTH(8), .RX_TIMEOUT(50)) dut (
    .internal_clk       (clk),
    .rst_n              (rst_n),
    .cfg_mode_en        (mode),
    .rx_flag_mcu        (rx),
    .data_from_uart_mcu (din),
    .tx_busy_mcu        (txb),
    .tx_use_mcu         (tx_use),
    .data_to_uart_mcu   (dout),
    .addh               (addh),
    .addl               (addl),
    .sped               (sped),
    .chan               (chan),
    .option             (option),
    .cfg_save           (cfg_save),
    .soft_reset_req     (srst),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  localparam logic [39:0] DEFS = 40'h00_00_1A_17_44;

  // Monitor: log every reply byte and count pulses / pacing violations.
  logic [7:0] txlog [512];
  int n_tx = 0, n_save = 0, n_srst = 0, n_b2b = 0, n_busyviol = 0;
  logic prev_use = 1'b0;
  always @(negedge clk) begin
    if (tx_use) begin
      if (n_tx < 512) txlog[n_tx] = dout;
      n_tx++;
      if (prev_use) n_b2b++;
      if (txb) n_busyviol++;
    end
    if (cfg_save) n_save++;
    if (srst) n_srst++;
    prev_use = tx_use;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx = 1'b1; din = b;
    tick();
    rx = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin tick(); k++; end
    chk("idle_bound", 64'(busy), 64'd0);
    tick(3);
  endtask

  function automatic logic [47:0] reply_since(input int t0);
    logic [47:0] r = '0;
    for (int i = t0; i < n_tx && i < t0 + 6 && i < 512; i++) r = {r[39:0], txlog[i]};
    return r;
  endfunction

  function automatic logic [39:0] regs();
    return {addh, addl, sped, chan, option};
  endfunction

  typedef struct {
    logic [47:0] bytes;   // first byte in [47:40]
    int          n;
    logic [39:0] regs;
    logic [47:0] rep;     // right-aligned reply bytes
    int          rep_n;
    int          save;
    int          srst;
  } vec_t;

  function automatic vec_t mk(input logic [47:0] b, input int n, input logic [39:0] r,
                              input logic [47:0] rp, input int rn, input int sv, input int sr);
    vec_t v;
    v.bytes = b; v.n = n; v.regs = r; v.rep = rp; v.rep_n = rn; v.save = sv; v.srst = sr;
    return v;
  endfunction

  task automatic run_vec(input string nm, input vec_t v);
    int t0 = n_tx, s0 = n_save, r0 = n_srst;
    logic [47:0] b = v.bytes;
    for (int i = 0; i < v.n; i++) begin
      send(b[47:40]);
      b = b << 8;
    end
    wait_idle();
    chk({nm, "_regs"}, 64'(regs()), 64'(v.regs));
    chk({nm, "_nbytes"}, 64'(n_tx - t0), 64'(v.rep_n));
    chk({nm, "_reply"}, 64'(reply_since(t0)), 64'(v.rep));
    chk({nm, "_save"}, 64'(n_save - s0), 64'(v.save));
    chk({nm, "_srst"}, 64'(n_srst - r0), 64'(v.srst));
  endtask

  vec_t vecs [7];

  initial begin
    int t0, s0;
    vecs[0] = mk(48'hC0_12_34_1D_05_44, 6, 40'h12_34_1D_05_44, 48'hC0_12_34_1D_05_44, 6, 1, 0);
    vecs[1] = mk(48'hC2_AA_BB_1A_17_44, 6, 40'hAA_BB_1A_17_44, 48'hC2_AA_BB_1A_17_44, 6, 0, 0);
    vecs[2] = mk(48'hC1_C1_C1_00_00_00, 3, 40'hAA_BB_1A_17_44, 48'hC0_AA_BB_1A_17_44, 6, 0, 0);
    vecs[3] = mk(48'hC1_C3_C1_C1_C1_00, 5, 40'hAA_BB_1A_17_44, 48'hC0_AA_BB_1A_17_44, 6, 0, 0);
    vecs[4] = mk(48'hC4_C4_C4_00_00_00, 3, 40'hAA_BB_1A_17_44, 48'h0, 0, 0, 1);
    vecs[5] = mk(48'h55_00_00_00_00_00, 1, 40'hAA_BB_1A_17_44, 48'h0, 0, 0, 0);
    vecs[6] = mk(48'hC3_C3_C3_00_00_00, 3, 40'hAA_BB_1A_17_44, 48'h0000_C332_2702, 4, 0, 0);

    tick(3);
    chk("rst_regs", 64'(regs()), 64'(DEFS));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_use", 64'(tx_use), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_pulses", 64'({cfg_save, srst}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Version request held off by a busy UART.
    txb = 1'b1;
    t0 = n_tx;
    send(8'hC3); send(8'hC3); send(8'hC3);
    tick(20);
    chk("hold_no_strobe", 64'(n_tx - t0), 64'd0);
    chk("hold_busy", 64'(busy), 64'd1);
    txb = 1'b0;
    wait_idle();
    chk("hold_nbytes", 64'(n_tx - t0), 64'd4);
    chk("hold_reply", 64'(reply_since(t0)), 64'h0000_C332_2702);

    // Mode drop mid-frame aborts; trailing bytes are not headers.
    t0 = n_tx;
    send(8'hC2);
    chk("abort_busy_hi", 64'(busy), 64'd1);
    send(8'h01);
    mode = 1'b0; tick();
    mode = 1'b1; tick();
    chk("abort_busy_lo", 64'(busy), 64'd0);
    send(8'h02); send(8'h03); send(8'h04);
    wait_idle();
    chk("abort_regs", 64'(regs()), 64'h00AA_BB1A_1744);
    chk("abort_notx", 64'(n_tx - t0), 64'd0);

    // Reset in the middle of a frame.
    send(8'hC0); send(8'h01); send(8'h02);
    rst_n = 1'b0;
    tick();
    chk("midrst_regs", 64'(regs()), 64'(DEFS));
    chk("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();
    run_vec("postrst", mk(48'hC1_C1_C1_00_00_00, 3, DEFS, 48'hC0_00_00_1A_17_44, 6, 0, 0));

    // Inter-byte timeout discards the partial frame.
    t0 = n_tx; s0 = n_save;
    send(8'hC0); send(8'h11); send(8'h22);
    chk("tmo_busy_hi", 64'(busy), 64'd1);
    tick(60);
    chk("tmo_busy_lo", 64'(busy), 64'd0);
    send(8'h33); send(8'h44); send(8'h55);
    wait_idle();
    chk("tmo_regs", 64'(regs()), 64'(DEFS));
    chk("tmo_notx", 64'(n_tx - t0), 64'd0);
    chk("tmo_nosave", 64'(n_save - s0), 64'd0);

    chk("no_b2b_strobe", 64'(n_b2b), 64'd0);
    chk("no_strobe_when_busy", 64'(n_busyviol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
